mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates the single-ported, 16-bit, synchronous-read memory block between two requesters: the CPU memory path (fetch and data) and a DMA/IO requester. It sits between the requesters and the memory's address, write-enable and write-data inputs. The CPU has priority, with a starvation guard that guarantees DMA service. DMA may lock short bursts. Read data is broadcast to both requesters, and a registered per-requester valid qualifies it.

## Interface
Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, data width
- STARVE_LIMIT, 4, consecutive CPU grants with DMA pending before DMA is forced in (≥1)
- BURST_MAX, 8, maximum consecutive locked DMA grants while the CPU is pending (≥1)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- cpu_req  in  1  CPU requests an access this cycle
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU access issued this cycle; 0 while requesting = stall
- cpu_rvalid  out  1  mem_rdata holds data for the CPU read granted in the previous cycle
- dma_req  in  1  DMA requests an access
- dma_we  in  1  DMA write
- dma_lock  in  1  DMA asks to keep the grant next cycle
- dma_addr  in  ADDR_W  DMA address
- dma_wdata  in  DATA_W  DMA write data
- dma_gnt  out  1  DMA access issued this cycle
- dma_rvalid  out  1  DMA read data valid
- mem_addr  out  ADDR_W  address to memory
- mem_we  out  1  memory write enable
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid 1 cycle after address
- rdata  out  DATA_W  mem_rdata passed through combinationally

## Operation
- State: owner register with values IDLE, CPU, DMA. Also a starve counter (0..STARVE_LIMIT) and a burst counter (0..BURST_MAX).
- Grant decision is combinational from the requests and registered state. At most one grant is active per cycle.
  - If the previous owner was DMA, dma_lock was 1 last cycle, dma_req=1, and burst_cnt < BURST_MAX: grant DMA.
  - Otherwise, if dma_req=1 and starve_cnt == STARVE_LIMIT: grant DMA.
  - Otherwise, if cpu_req=1: grant CPU.
  - Otherwise, if dma_req=1: grant DMA.
  - Otherwise: no grant.
- The locked-burst rule overrides the CPU. When the CPU is idle, DMA may exceed BURST_MAX, with the counter saturating.
- Muxing: mem_addr, mem_we and mem_wdata come from the granted requester. With no grant, mem_addr=0, mem_wdata=0 and mem_we=0. mem_we is never 1 without a grant.
- Owner transitions at each edge: CPU if cpu_gnt, DMA if dma_gnt, IDLE otherwise.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) on a CPU grant with dma_req=1.
  - Clears on a DMA grant or when dma_req=0.
- Burst counter:
  - Increments (saturating) on a DMA grant while cpu_req=1.
  - Clears on a CPU grant or on a cycle with no DMA grant.
  - Reset to 1 on a DMA grant when the previous owner was not DMA.
- Read valid: cpu_rvalid is set the cycle after a CPU read grant (cpu_we=0); dma_rvalid likewise for DMA. Writes produce no rvalid.

## Timing
- Grant is same-cycle, combinational from req. Requesters hold req, addr, we and wdata stable until they see gnt=1.
- Read latency is 1 cycle. For back-to-back reads, rvalid follows each grant by exactly one cycle, and consecutive rvalids may alternate between owners.
- While reset=0, cpu_gnt, dma_gnt and mem_we are forced to 0 combinationally.
- At the reset edge: owner=IDLE, both counters 0, cpu_rvalid=0, dma_rvalid=0. A reset in the middle of a burst discards the lock, and an in-flight rvalid is dropped.
- When both requesters assert in the same cycle with no lock and no starvation, the CPU wins.
- No combinational path exists from mem_rdata to any control output.

## Structure
- Package mem_arb_pkg holds the owner enum (OWN_IDLE, OWN_CPU, OWN_DMA) and the default parameter values.
- One natural sub-module, arb_sat_counter, is a saturating counter with clear, load-1 and increment controls and a parameterised limit. It is instantiated twice: once for starvation, once for bursts.

## Test plan
- Single CPU read at 0x0010, memory returning 0xBEEF: cpu_gnt same cycle, mem_addr=0x0010, next cycle cpu_rvalid=1 and rdata=0xBEEF, dma_rvalid=0.
- CPU and DMA requesting continuously, STARVE_LIMIT=4: grant sequence C,C,C,C,D,C,C,C,C,D…; mem_addr tracks the winner each cycle.
- DMA with dma_lock=1 and the CPU pending, BURST_MAX=8: exactly 8 DMA grants, then one CPU grant, with burst_cnt restarting at 1 on the next DMA grant.
- DMA write 0x1234 to 0x0200, then DMA read of 0x0200: mem_we=1 only in the write cycle, dma_rvalid only after the read, and data 0x1234.
- reset=0 asserted mid-burst with both requesting: no grants and mem_we=0 during reset. After release, the CPU wins the first cycle and both rvalids are 0 in the cycle after release.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the memory port arbiter.
// Owner encoding tracks who held the memory port last cycle.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

  localparam int DEF_ADDR_W       = 16;
  localparam int DEF_DATA_W       = 16;
  localparam int DEF_STARVE_LIMIT = 4;
  localparam int DEF_BURST_MAX    = 8;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating counter with clear, load-one and increment controls.
// Clear wins over load-one, which wins over increment.
module arb_sat_counter #(
  parameter int LIMIT = 4,
  parameter int CW    = $clog2(LIMIT + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_ld1,
  input  logic          i_inc,
  output logic [CW-1:0] o_cnt
);

  logic [CW-1:0] r_cnt;
  logic          w_sat;

  assign w_sat = (r_cnt == CW'(LIMIT));
  assign o_cnt = r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_ld1) begin
      r_cnt <= CW'(1);
    end else if (i_inc && !w_sat) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// CPU/DMA arbiter for a single-ported synchronous-read memory.
// CPU has priority; starvation guard and locked DMA bursts override it.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int BURST_MAX    = DEF_BURST_MAX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic              dma_lock,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int BW = $clog2(BURST_MAX + 1);

  owner_e        r_owner;
  owner_e        w_owner_nxt;
  logic          r_lock;
  logic          r_cpu_rv;
  logic          r_dma_rv;
  logic [SW-1:0] w_starve;
  logic [BW-1:0] w_burst;
  logic          w_cpu_gnt;
  logic          w_dma_gnt;
  logic          w_hold;
  logic          w_starved;

  always_comb begin
    w_cpu_gnt   = 1'b0;
    w_dma_gnt   = 1'b0;
    w_hold      = (r_owner == OWN_DMA) && r_lock && dma_req
                  && (w_burst < BW'(BURST_MAX));
    w_starved   = dma_req && (w_starve == SW'(STARVE_LIMIT));
    w_owner_nxt = OWN_IDLE;
    if (reset) begin
      if (w_hold || w_starved) begin
        w_dma_gnt = 1'b1;
      end else if (cpu_req) begin
        w_cpu_gnt = 1'b1;
      end else if (dma_req) begin
        w_dma_gnt = 1'b1;
      end
    end
    if (w_cpu_gnt) begin
      w_owner_nxt = OWN_CPU;
    end else if (w_dma_gnt) begin
      w_owner_nxt = OWN_DMA;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_owner  <= OWN_IDLE;
      r_lock   <= 1'b0;
      r_cpu_rv <= 1'b0;
      r_dma_rv <= 1'b0;
    end else begin
      r_owner  <= w_owner_nxt;
      r_lock   <= dma_lock;
      r_cpu_rv <= w_cpu_gnt && !cpu_we;
      r_dma_rv <= w_dma_gnt && !dma_we;
    end
  end

  arb_sat_counter #(.LIMIT(STARVE_LIMIT), .CW(SW)) u_starve (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_clr   (w_dma_gnt || !dma_req),
    .i_ld1   (1'b0),
    .i_inc   (w_cpu_gnt && dma_req),
    .o_cnt   (w_starve)
  );

  // A fresh DMA ownership starts the burst count at one.
  arb_sat_counter #(.LIMIT(BURST_MAX), .CW(BW)) u_burst (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_clr   (!w_dma_gnt),
    .i_ld1   (w_dma_gnt && (r_owner != OWN_DMA)),
    .i_inc   (w_dma_gnt && cpu_req),
    .o_cnt   (w_burst)
  );

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (w_cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we;
    end else if (w_dma_gnt) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      mem_we    = dma_we;
    end
  end

  assign cpu_gnt    = w_cpu_gnt;
  assign dma_gnt    = w_dma_gnt;
  assign cpu_rvalid = r_cpu_rv;
  assign dma_rvalid = r_dma_rv;
  assign rdata      = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small synchronous memory.
// Inputs change just after negedge; checks run 1 time unit later.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr, cpu_wdata;
  logic        cpu_gnt, cpu_rvalid;
  logic        dma_req, dma_we, dma_lock;
  logic [15:0] dma_addr, dma_wdata;
  logic        dma_gnt, dma_rvalid;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, rdata;
  logic        mem_we;

  int tests = 0;
  int fails = 0;

  logic [15:0] mem [0:1023];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[9:0]];
  end

  mem_port_arbiter #(
    .ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(4), .BURST_MAX(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_lock   (dma_lock),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_gnt    (dma_gnt),
    .dma_rvalid (dma_rvalid),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .rdata      (rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_gnt(input string tag, input logic c, input logic d);
    chk({tag, "_cgnt"}, 32'(cpu_gnt), 32'(c));
    chk({tag, "_dgnt"}, 32'(dma_gnt), 32'(d));
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'(i);
    mem[16] = 16'hBEEF;
    mem_rdata = '0;
    reset = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0; cpu_wdata = 16'h0;
    dma_req = 1'b1; dma_we = 1'b1; dma_lock = 1'b0;
    dma_addr = 16'h0; dma_wdata = 16'h0;

    // reset state
    nxt(); nxt(); settle();
    chk_gnt("rst", 1'b0, 1'b0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_crv", 32'(cpu_rvalid), 32'd0);
    chk("rst_drv", 32'(dma_rvalid), 32'd0);

    reset = 1'b1; cpu_req = 1'b0; dma_req = 1'b0;
    cpu_we = 1'b0; dma_we = 1'b0;
    nxt();

    // single CPU read
    cpu_req = 1'b1; cpu_addr = 16'h0010; settle();
    chk_gnt("crd", 1'b1, 1'b0);
    chk("crd_addr", 32'(mem_addr), 32'h0010);
    chk("crd_we", 32'(mem_we), 32'd0);
    nxt(); cpu_req = 1'b0; settle();
    chk("crd_crv", 32'(cpu_rvalid), 32'd1);
    chk("crd_drv", 32'(dma_rvalid), 32'd0);
    chk("crd_data", 32'(rdata), 32'hBEEF);
    nxt();

    // starvation guard: C,C,C,C,D repeating
    cpu_req = 1'b1; cpu_addr = 16'h0100;
    dma_req = 1'b1; dma_addr = 16'h0200;
    for (int i = 0; i < 10; i++) begin
      settle();
      if (i % 5 == 4) begin
        chk_gnt("stv", 1'b0, 1'b1);
        chk("stv_addr", 32'(mem_addr), 32'h0200);
      end else begin
        chk_gnt("stv", 1'b1, 1'b0);
        chk("stv_addr", 32'(mem_addr), 32'h0100);
      end
      if (i > 0) begin
        chk("stv_crv", 32'(cpu_rvalid), 32'(i % 5 != 0));
        chk("stv_drv", 32'(dma_rvalid), 32'(i % 5 == 0));
      end
      nxt();
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    nxt();

    // locked burst: DMA alone first, then CPU pending
    dma_req = 1'b1; dma_lock = 1'b1; settle();
    chk_gnt("bst0", 1'b0, 1'b1);
    nxt(); cpu_req = 1'b1;
    for (int i = 0; i < 7; i++) begin
      settle();
      chk_gnt("bst", 1'b0, 1'b1);
      nxt();
    end
    settle();
    chk_gnt("bst_end", 1'b1, 1'b0);
    chk("bst_end_addr", 32'(mem_addr), 32'h0100);
    nxt();
    for (int i = 0; i < 3; i++) begin
      settle();
      chk_gnt("bst_cpu", 1'b1, 1'b0);
      nxt();
    end
    // starvation reclaims DMA; the burst count restarts at one
    for (int i = 0; i < 8; i++) begin
      settle();
      chk_gnt("bst2", 1'b0, 1'b1);
      nxt();
    end
    settle();
    chk_gnt("bst2_end", 1'b1, 1'b0);
    nxt();
    cpu_req = 1'b0; dma_req = 1'b0; dma_lock = 1'b0;
    nxt();

    // DMA write then read back
    dma_req = 1'b1; dma_we = 1'b1;
    dma_addr = 16'h0200; dma_wdata = 16'h1234; settle();
    chk_gnt("dwr", 1'b0, 1'b1);
    chk("dwr_we", 32'(mem_we), 32'd1);
    chk("dwr_wd", 32'(mem_wdata), 32'h1234);
    nxt(); dma_we = 1'b0; settle();
    chk_gnt("drd", 1'b0, 1'b1);
    chk("drd_we", 32'(mem_we), 32'd0);
    chk("drd_drv", 32'(dma_rvalid), 32'd0);
    nxt(); dma_req = 1'b0; settle();
    chk("drd_drv2", 32'(dma_rvalid), 32'd1);
    chk("drd_crv2", 32'(cpu_rvalid), 32'd0);
    chk("drd_data", 32'(rdata), 32'h1234);
    chk("drd_idle_we", 32'(mem_we), 32'd0);
    chk_gnt("drd_idle", 1'b0, 1'b0);
    nxt();

    // reset in the middle of a locked burst
    dma_req = 1'b1; dma_lock = 1'b1; settle();
    chk_gnt("mr0", 1'b0, 1'b1);
    nxt(); cpu_req = 1'b1; settle();
    chk_gnt("mr1", 1'b0, 1'b1);
    nxt();
    reset = 1'b0; cpu_we = 1'b1; dma_we = 1'b1; settle();
    chk_gnt("mr_rst", 1'b0, 1'b0);
    chk("mr_rst_we", 32'(mem_we), 32'd0);
    chk("mr_rst_addr", 32'(mem_addr), 32'd0);
    nxt(); settle();
    chk_gnt("mr_rst2", 1'b0, 1'b0);
    chk("mr_rst2_we", 32'(mem_we), 32'd0);
    chk("mr_rst2_drv", 32'(dma_rvalid), 32'd0);
    nxt();
    reset = 1'b1; cpu_we = 1'b0; dma_we = 1'b0; settle();
    chk_gnt("mr_rel", 1'b1, 1'b0);
    chk("mr_rel_crv", 32'(cpu_rvalid), 32'd0);
    chk("mr_rel_drv", 32'(dma_rvalid), 32'd0);
    nxt(); settle();
    chk("mr_rel2_crv", 32'(cpu_rvalid), 32'd1);
    cpu_req = 1'b0; dma_req = 1'b0; dma_lock = 1'b0;
    nxt();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
